hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the ID/EX pipeline buffer and the front end (PC, IF/ID).
- Detects load-use hazards and inserts one bubble into ID/EX.
- Freezes PC, IF/ID and ID/EX while a multi-cycle MUL occupies EX.
- Flushes IF/ID on a taken branch resolved in ID.
- State is registered; all control outputs are combinational from state and the current-cycle inputs, so the pipeline registers act on the same posedge.

Parameters:
MUL_LAT, 3, total cycles a MUL instruction stays in EX (legal 1..16)
REG_W, 5, register-index width

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  asynchronous, active-low reset
id_rs1_i  in  REG_W  rs1 index of instruction in ID
id_rs2_i  in  REG_W  rs2 index of instruction in ID
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
id_valid_i  in  1  ID holds a real instruction
ex_rsd_i  in  REG_W  rsd from ID/EX output
ex_op_i  in  3  Op from ID/EX output
ex_valid_i  in  1  valid from ID/EX output
branch_taken_i  in  1  branch in ID resolved taken this cycle
pc_write_o  out  1  PC may update
ifid_write_o  out  1  IF/ID may load
ifid_flush_o  out  1  IF/ID loads a bubble (valid=0)
idex_valid_o  out  1  gated valid fed to the ID/EX valid input (0 = bubble)
idex_hold_o  out  1  ID/EX keeps its contents (enable low)
mul_busy_o  out  1  FSM in MUL_BUSY

Behaviour:
- Definitions:
  - lu_hz = ex_valid_i & ex_op_i==OP_LW & ex_rsd_i!=0 & id_valid_i & ((id_use_rs1_i & id_rs1_i==ex_rsd_i) | (id_use_rs2_i & id_rs2_i==ex_rsd_i)).
  - mul_ex = ex_valid_i & ex_op_i==OP_MUL & MUL_LAT>1.
- States: RUN, MUL_BUSY. 4-bit counter cnt.
- Reset (rst_i low, asynchronous):
  - State goes to RUN, cnt=0.
  - Outputs held at pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_valid_o=0, idex_hold_o=0, mul_busy_o=0.
  - Reset mid-MUL abandons the MUL immediately.
- Priority each cycle: MUL hold > load-use > branch flush > normal.
- MUL hold. Condition: (RUN & mul_ex) or (MUL_BUSY & cnt!=0).
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_hold_o=1, ifid_flush_o=0, idex_valid_o=id_valid_i (ignored while held).
  - RUN & mul_ex: next state MUL_BUSY, cnt<=MUL_LAT-2.
  - MUL_BUSY & cnt!=0: cnt<=cnt-1.
  - MUL_BUSY & cnt==0: no hold, normal rules apply, next state RUN.
  - Net effect: exactly MUL_LAT-1 hold cycles; the MUL resides in EX for MUL_LAT cycles.
- Load-use (no MUL hold, lu_hz): pc_write_o=0, ifid_write_o=0, idex_valid_o=0, idex_hold_o=0, ifid_flush_o=0.
  - Exactly one bubble. The next cycle the LW has left EX, so lu_hz clears.
  - branch_taken_i is ignored this cycle; the branch is re-evaluated next cycle.
- Branch (no hold, no lu_hz, branch_taken_i): pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_valid_o=id_valid_i.
- Normal: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_hold_o=0, idex_valid_o=id_valid_i.
- x0 never creates a hazard.
- ex_valid_i=0 masks every EX-side condition.
- Back-to-back MULs: a new MUL reaching EX in the cycle after release re-enters MUL_BUSY. There is no idle gap.
- MUL_LAT=1: MUL_BUSY is never entered.

Optional Feature:
- Macro HAZARD_CTRL_STATS_EN.
- When defined:
  - Adds outputs stall_cnt_o[31:0], flush_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o increments each cycle pc_write_o=0 outside reset.
  - flush_cnt_o increments each cycle ifid_flush_o=1 outside reset.
  - bubble_cnt_o increments on each load-use bubble.
  - All three saturate at 32'hFFFFFFFF and clear asynchronously on reset.
- When undefined: the ports and logic do not exist; core behaviour is identical.

Decomposition:
- Package pipe_pkg holds OP_* encodings (OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_MUL=3'b011, OP_OR=3'b100, OP_LW=3'b101, OP_SW=3'b110, OP_BEQ=3'b111), the state enum {RUN, MUL_BUSY} and REG_W.
- One sub-module: hazard_detect, the purely combinational lu_hz comparator (reused by the forwarding unit).

Test Plan:
- Reset asserted mid-MUL_BUSY (MUL_LAT=3, cnt=1) -> same cycle pc_write_o=0, ifid_flush_o=1, mul_busy_o=0; after release RUN with cnt=0.
- EX: LW x5 valid; ID: add x6,x5,x7 with use_rs1=1 -> exactly one cycle pc_write_o=0, idex_valid_o=0; next cycle normal.
- EX: LW x0; ID reads x0 -> no stall. EX: LW x5 with ex_valid_i=0 -> no stall.
- MUL_LAT=3, MUL enters EX -> idex_hold_o=1 for 2 cycles, mul_busy_o=1 for 2 cycles, then normal. Second MUL immediately behind -> another 2 hold cycles.
- branch_taken_i=1 with no hazard -> ifid_flush_o=1, pc_write_o=1 for one cycle. branch_taken_i=1 together with lu_hz -> ifid_flush_o=0, stall only.
- With HAZARD_CTRL_STATS_EN: one load-use plus one MUL (MUL_LAT=3) plus one branch -> stall_cnt_o=3, bubble_cnt_o=1, flush_cnt_o=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg: shared opcode encodings, sequencer states and register-index width
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_BEQ = 3'b111;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect: combinational load-use comparator between ID sources and EX load
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ex_rsd,
  input  logic [2:0]       ex_op,
  input  logic             ex_valid,
  output logic             lu_hz
);
  import pipe_pkg::*;

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1 && (rs1 == ex_rsd);
  assign rs2_hit = use_rs2 && (rs2 == ex_rsd);

  // x0 is hard-wired, so a load targeting it never produces a dependency
  assign lu_hz = ex_valid && (ex_op == OP_LW) && (ex_rsd != '0) && id_valid
                 && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl: PC / IF/ID / ID/EX sequencing for load-use, multi-cycle MUL and branch flush
// rev 1.0 -- optional event counters with HAZARD_CTRL_STATS_EN
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int REG_W   = pipe_pkg::REG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] ex_rsd_i,
  input  logic [2:0]       ex_op_i,
  input  logic             ex_valid_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_valid_o,
  output logic             idex_hold_o,
  output logic             mul_busy_o
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o,
  output logic [31:0]      bubble_cnt_o
`endif
);
  import pipe_pkg::*;

  localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_e     state;
  state_e     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       lu_hz;
  logic       mul_ex;
  logic       mul_hold;

  assign mul_ex = ex_valid_i && (ex_op_i == OP_MUL) && (MUL_LAT > 1);

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .use_rs1  (id_use_rs1_i),
    .use_rs2  (id_use_rs2_i),
    .id_valid (id_valid_i),
    .ex_rsd   (ex_rsd_i),
    .ex_op    (ex_op_i),
    .ex_valid (ex_valid_i),
    .lu_hz    (lu_hz)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mul_hold     = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_valid_o = id_valid_i;
    idex_hold_o  = 1'b0;
    mul_busy_o   = (state == MUL_BUSY);

    // The release cycle (cnt==0) still has the old MUL in EX, so it must not re-trigger
    case (state)
      RUN: begin
        if (mul_ex) begin
          mul_hold  = 1'b1;
          state_nxt = MUL_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (cnt != 4'd0) begin
          mul_hold = 1'b1;
          cnt_nxt  = cnt - 4'd1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (mul_hold) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_hold_o  = 1'b1;
    end else if (lu_hz) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_valid_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end

    if (!rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b1;
      idex_valid_o = 1'b0;
      idex_hold_o  = 1'b0;
      mul_busy_o   = 1'b0;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic lu_bubble;

  assign lu_bubble = !mul_hold && lu_hz;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= 32'd0;
      flush_cnt_o  <= 32'd0;
      bubble_cnt_o <= 32'd0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (ifid_flush_o && (flush_cnt_o != 32'hFFFF_FFFF)) flush_cnt_o <= flush_cnt_o + 32'd1;
      if (lu_bubble && (bubble_cnt_o != 32'hFFFF_FFFF)) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl: directed scenarios plus randomized run against a cycle-level pipeline model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs1, rs2, ex_rsd;
  logic       use1, use2, idv, exv, br;
  logic [2:0] ex_op;

  logic pc3, ifw3, iff3, idv3, idh3, busy3;
  logic pc1, ifw1, iff1, idv1, idh1, busy1;
  logic [5:0] obs3, obs1;
  assign obs3 = {pc3, ifw3, iff3, idv3, idh3, busy3};
  assign obs1 = {pc1, ifw1, iff1, idv1, idh1, busy1};

`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] st3, fl3, bu3, st1, fl1, bu1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(3), .REG_W(5)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_valid_i(idv),
    .ex_rsd_i(ex_rsd), .ex_op_i(ex_op), .ex_valid_i(exv), .branch_taken_i(br),
    .pc_write_o(pc3), .ifid_write_o(ifw3), .ifid_flush_o(iff3),
    .idex_valid_o(idv3), .idex_hold_o(idh3), .mul_busy_o(busy3)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cnt_o(st3), .flush_cnt_o(fl3), .bubble_cnt_o(bu3)
`endif
  );

  hazard_ctrl #(.MUL_LAT(1), .REG_W(5)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_valid_i(idv),
    .ex_rsd_i(ex_rsd), .ex_op_i(ex_op), .ex_valid_i(exv), .branch_taken_i(br),
    .pc_write_o(pc1), .ifid_write_o(ifw1), .ifid_flush_o(iff1),
    .idex_valid_o(idv1), .idex_hold_o(idh1), .mul_busy_o(busy1)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cnt_o(st1), .flush_cnt_o(fl1), .bubble_cnt_o(bu1)
`endif
  );

  // Model: age = cycles the current MUL has already spent in EX (-1 = none resident)
  int age3 = -1, age1 = -1;
  logic [31:0] m_stall = 0, m_flush = 0, m_bubble = 0;

  function automatic bit f_lu();
    return exv && ex_op == OP_LW && ex_rsd != 0 && idv &&
           ((use1 && rs1 == ex_rsd) || (use2 && rs2 == ex_rsd));
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_valid, idex_hold, mul_busy}
  function automatic logic [5:0] f_exp(input int age, input int lat);
    bit hold, busy;
    if (!rst_i) return 6'b001000;
    if (age >= 0) hold = (age < lat - 1);
    else          hold = exv && ex_op == OP_MUL && lat > 1;
    busy = (age >= 1);
    if (hold)   return {3'b000, idv, 1'b1, busy};
    if (f_lu()) return {5'b00000, busy};
    if (br)     return {3'b111, idv, 1'b0, busy};
    return {3'b110, idv, 1'b0, busy};
  endfunction

  function automatic bit f_bit(input int age, input int lat, input int idx);
    logic [5:0] e;
    e = f_exp(age, lat);
    return e[idx];
  endfunction

  function automatic int f_next(input int age, input int lat);
    if (age >= 0) return (age + 1 >= lat) ? -1 : age + 1;
    if (exv && ex_op == OP_MUL && lat > 1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      age3 <= -1; age1 <= -1;
      m_stall <= 0; m_flush <= 0; m_bubble <= 0;
    end else begin
      if (!f_bit(age3, 3, 5)) m_stall <= m_stall + 1;
      if (f_bit(age3, 3, 3))  m_flush <= m_flush + 1;
      if (!f_bit(age3, 3, 5) && !f_bit(age3, 3, 1)) m_bubble <= m_bubble + 1;
      age3 <= f_next(age3, 3);
      age1 <= f_next(age1, 1);
    end
  end

  task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic u1, input logic u2,
                     input logic v, input logic [4:0] rd, input logic [2:0] op,
                     input logic ev, input logic bt);
    @(negedge clk);
    rs1 = a; rs2 = b; use1 = u1; use2 = u2; idv = v;
    ex_rsd = rd; ex_op = op; exv = ev; br = bt;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    rs1 = 0; rs2 = 0; use1 = 0; use2 = 0; idv = 0; ex_rsd = 0; ex_op = OP_ADD; exv = 0; br = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (obs3 !== 6'b001000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs3, 6'b001000); end
    checks++; if (obs1 !== 6'b001000) begin errors++; $display("FAIL reset_outputs_lat1: got %b expected %b", obs1, 6'b001000); end
    rst_i = 1'b1;
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000110) begin errors++; $display("FAIL reset_pre_mul_entry: got %b expected %b", obs3, 6'b000110); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000111) begin errors++; $display("FAIL reset_pre_mul_busy: got %b expected %b", obs3, 6'b000111); end
    rst_i = 1'b0;
    #1;
    checks++; if (obs3 !== 6'b001000) begin errors++; $display("FAIL reset_mid_mul: got %b expected %b", obs3, 6'b001000); end
    exv = 1'b0; ex_op = OP_ADD;
    @(negedge clk);
    rst_i = 1'b1;
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000110) begin errors++; $display("FAIL reset_rerun_entry: got %b expected %b", obs3, 6'b000110); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000111) begin errors++; $display("FAIL reset_rerun_count: got %b expected %b", obs3, 6'b000111); end
    idle(3);
  endtask

  task automatic test_load_use();
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, OP_LW, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000000) begin errors++; $display("FAIL lu_rs1_stall: got %b expected %b", obs3, 6'b000000); end
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, OP_LW, 1'b0, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL lu_after_bubble: got %b expected %b", obs3, 6'b110100); end
    cyc(5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, OP_LW, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000000) begin errors++; $display("FAIL lu_rs2_stall: got %b expected %b", obs3, 6'b000000); end
    cyc(5'd9, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, OP_LW, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL lu_unused_src: got %b expected %b", obs3, 6'b110100); end
  endtask

  task automatic test_x0_and_invalid();
    cyc(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, OP_LW, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL lu_x0: got %b expected %b", obs3, 6'b110100); end
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, OP_LW, 1'b0, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL lu_ex_invalid: got %b expected %b", obs3, 6'b110100); end
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, OP_LW, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110000) begin errors++; $display("FAIL lu_id_invalid: got %b expected %b", obs3, 6'b110000); end
  endtask

  task automatic test_mul();
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b000110) begin errors++; $display("FAIL mul_entry: got %b expected %b", obs3, 6'b000110); end
    checks++; if (obs1 !== 6'b110100) begin errors++; $display("FAIL mul_lat1_no_hold: got %b expected %b", obs1, 6'b110100); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b1);
    checks++; if (obs3 !== 6'b000111) begin errors++; $display("FAIL mul_hold2: got %b expected %b", obs3, 6'b000111); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110101) begin errors++; $display("FAIL mul_release: got %b expected %b", obs3, 6'b110101); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL mul_after: got %b expected %b", obs3, 6'b110100); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want [6] = '{6'b000110, 6'b000111, 6'b110101, 6'b000110, 6'b000111, 6'b110101};
    for (int i = 0; i < 6; i++) begin
      cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
      checks++; if (obs3 !== want[i]) begin errors++; $display("FAIL mul_b2b[%0d]: got %b expected %b", i, obs3, want[i]); end
    end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL mul_b2b_after: got %b expected %b", obs3, 6'b110100); end
  endtask

  task automatic test_branch();
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b1, 1'b1);
    checks++; if (obs3 !== 6'b111100) begin errors++; $display("FAIL branch_flush: got %b expected %b", obs3, 6'b111100); end
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b1, 1'b0);
    checks++; if (obs3 !== 6'b110100) begin errors++; $display("FAIL branch_after: got %b expected %b", obs3, 6'b110100); end
    cyc(5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, OP_LW, 1'b1, 1'b1);
    checks++; if (obs3 !== 6'b000000) begin errors++; $display("FAIL branch_with_lu: got %b expected %b", obs3, 6'b000000); end
    cyc(5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, OP_LW, 1'b0, 1'b1);
    checks++; if (obs3 !== 6'b111100) begin errors++; $display("FAIL branch_reeval: got %b expected %b", obs3, 6'b111100); end
  endtask

`ifdef HAZARD_CTRL_STATS_EN
  task automatic test_stats();
    @(negedge clk); exv = 1'b0; br = 1'b0; rst_i = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, OP_LW, 1'b1, 1'b0);
    cyc(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, OP_LW, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_MUL, 1'b1, 1'b0);
    idle(1);
    cyc(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, OP_ADD, 1'b1, 1'b1);
    idle(2);
    checks++; if (st3 !== 32'd3) begin errors++; $display("FAIL stats_stall: got %0d expected %0d", st3, 3); end
    checks++; if (bu3 !== 32'd1) begin errors++; $display("FAIL stats_bubble: got %0d expected %0d", bu3, 1); end
    checks++; if (fl3 !== 32'd1) begin errors++; $display("FAIL stats_flush: got %0d expected %0d", fl3, 1); end
  endtask
`endif

  task automatic test_random();
    logic [5:0] e3, e1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_i  = ($urandom_range(0, 59) != 0);
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      ex_rsd = 5'($urandom_range(0, 3));
      use1   = 1'($urandom); use2 = 1'($urandom);
      idv    = ($urandom_range(0, 7) != 0);
      exv    = ($urandom_range(0, 5) != 0);
      br     = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: ex_op = OP_LW;
        1: ex_op = OP_MUL;
        default: ex_op = 3'($urandom);
      endcase
      #1;
      e3 = f_exp(age3, 3);
      e1 = f_exp(age1, 1);
      checks++; if (obs3 !== e3) begin errors++; $display("FAIL rand_lat3[%0d]: got %b expected %b", i, obs3, e3); end
      checks++; if (obs1 !== e1) begin errors++; $display("FAIL rand_lat1[%0d]: got %b expected %b", i, obs1, e1); end
`ifdef HAZARD_CTRL_STATS_EN
      checks++;
      if ({st3, fl3, bu3} !== {m_stall, m_flush, m_bubble}) begin
        errors++;
        $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, st3, fl3, bu3, m_stall, m_flush, m_bubble);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_and_invalid();
    test_mul();
    test_back_to_back();
    test_branch();
`ifdef HAZARD_CTRL_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
